// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file shared by the execute stage and the CLINT.
//
// Ports
//   clk, rst            : clock; synchronous active-high reset
//   we_i/waddr_i/data_i : ex-side write port (wins over the clint port)
//   raddr_i -> data_o   : ex-side combinational read with same-port forwarding
//   clint_we_i/clint_waddr_i/clint_data_i : clint-side write port
//   clint_raddr_i -> clint_data_o         : clint-side combinational read
//   clint_csr_mtvec/mepc/mstatus          : raw register views, not forwarded
//   global_int_en_o                       : mstatus.MIE (bit 3)
//
// Only address bits [11:0] are decoded. A 64-bit free-running counter is
// visible as mcycle/mcycleh (writable) and cycle/cycleh (read-only aliases).
module csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] raddr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    input  logic        clint_we_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_raddr_i,
    input  logic [31:0] clint_data_i,
    output logic [31:0] clint_data_o,
    output logic [31:0] clint_csr_mtvec,
    output logic [31:0] clint_csr_mepc,
    output logic [31:0] clint_csr_mstatus,
    output logic        global_int_en_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;

    logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
    logic [63:0] cycle_cnt;

    // Upper address bits are deliberately not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr_i[31:12], raddr_i[31:12],
                                clint_waddr_i[31:12], clint_raddr_i[31:12]};

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MCYCLEH: is_writable = 1'b1;
            default:             is_writable = 1'b0;
        endcase
    endfunction

    // Counter reads return the pre-increment (registered) value.
    function automatic logic [31:0] csr_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:           csr_read = mstatus;
            A_MIE:               csr_read = mie;
            A_MTVEC:             csr_read = mtvec;
            A_MSCRATCH:          csr_read = mscratch;
            A_MEPC:              csr_read = mepc;
            A_MCAUSE:            csr_read = mcause;
            A_MCYCLE, A_CYCLE:   csr_read = cycle_cnt[31:0];
            A_MCYCLEH, A_CYCLEH: csr_read = cycle_cnt[63:32];
            default:             csr_read = 32'h0;
        endcase
    endfunction

    // Single committed write per cycle; ex port has priority and the clint
    // write is dropped when both are enabled.
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    always_comb begin
        wr_en   = we_i | clint_we_i;
        wr_addr = we_i ? waddr_i[11:0] : clint_waddr_i[11:0];
        wr_data = we_i ? data_i : clint_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus   <= 32'h0;
            mie       <= 32'h0;
            mtvec     <= 32'h0;
            mscratch  <= 32'h0;
            mepc      <= 32'h0;
            mcause    <= 32'h0;
            cycle_cnt <= 64'h0;
        end else begin
            if (wr_en && wr_addr == A_MSTATUS)  mstatus  <= wr_data;
            if (wr_en && wr_addr == A_MIE)      mie      <= wr_data;
            if (wr_en && wr_addr == A_MTVEC)    mtvec    <= wr_data;
            if (wr_en && wr_addr == A_MSCRATCH) mscratch <= wr_data;
            if (wr_en && wr_addr == A_MEPC)     mepc     <= wr_data;
            if (wr_en && wr_addr == A_MCAUSE)   mcause   <= wr_data;
            // A write to either half freezes the other half for that cycle.
            if (wr_en && wr_addr == A_MCYCLE)
                cycle_cnt[31:0] <= wr_data;
            else if (wr_en && wr_addr == A_MCYCLEH)
                cycle_cnt[63:32] <= wr_data;
            else
                cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    // Read ports: forwarding only from the same port's own write.
    always_comb begin
        data_o       = 32'h0;
        clint_data_o = 32'h0;
        if (!rst) begin
            if (we_i && waddr_i[11:0] == raddr_i[11:0] && is_writable(waddr_i[11:0]))
                data_o = data_i;
            else
                data_o = csr_read(raddr_i[11:0]);

            if (clint_we_i && clint_waddr_i[11:0] == clint_raddr_i[11:0] &&
                is_writable(clint_waddr_i[11:0]))
                clint_data_o = clint_data_i;
            else
                clint_data_o = csr_read(clint_raddr_i[11:0]);
        end
    end

    assign clint_csr_mtvec   = rst ? 32'h0 : mtvec;
    assign clint_csr_mepc    = rst ? 32'h0 : mepc;
    assign clint_csr_mstatus = rst ? 32'h0 : mstatus;
    assign global_int_en_o   = rst ? 1'b0  : mstatus[3];

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] waddr_i, raddr_i, data_i, data_o;
    logic        clint_we_i;
    logic [31:0] clint_waddr_i, clint_raddr_i, clint_data_i, clint_data_o;
    logic [31:0] clint_csr_mtvec, clint_csr_mepc, clint_csr_mstatus;
    logic        global_int_en_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .raddr_i           (raddr_i),
        .data_i            (data_i),
        .data_o            (data_o),
        .clint_we_i        (clint_we_i),
        .clint_waddr_i     (clint_waddr_i),
        .clint_raddr_i     (clint_raddr_i),
        .clint_data_i      (clint_data_i),
        .clint_data_o      (clint_data_o),
        .clint_csr_mtvec   (clint_csr_mtvec),
        .clint_csr_mepc    (clint_csr_mepc),
        .clint_csr_mstatus (clint_csr_mstatus),
        .global_int_en_o   (global_int_en_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i = 1'b0; waddr_i = 32'h0; data_i = 32'h0;
        clint_we_i = 1'b0; clint_waddr_i = 32'h0; clint_data_i = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        raddr_i = 32'h0; clint_raddr_i = 32'h0;
        idle();
        tick(); tick();

        // Reset state
        check("rst_data_o", data_o, 32'h0);
        check("rst_clint_data_o", clint_data_o, 32'h0);
        check("rst_mtvec", clint_csr_mtvec, 32'h0);
        check("rst_mstatus", clint_csr_mstatus, 32'h0);
        check("rst_gie", {31'h0, global_int_en_o}, 32'h0);

        // Counter start: 0 before first released edge, 1 after it
        rst = 1'b0; raddr_i = 32'hC00; clint_raddr_i = 32'hC80;
        #1;
        check("cnt_start", data_o, 32'h0);
        tick();
        check("cnt_first", data_o, 32'h1);
        check("cnt_first_h", clint_data_o, 32'h0);

        // ex write mtvec with same-cycle forwarding
        we_i = 1'b1; waddr_i = 32'h305; data_i = 32'h8000_0100; raddr_i = 32'h305;
        #1;
        check("ex_fwd_mtvec", data_o, 32'h8000_0100);
        check("mtvec_not_fwd", clint_csr_mtvec, 32'h0);
        tick(); idle();
        check("mtvec_out", clint_csr_mtvec, 32'h8000_0100);
        check("mtvec_read", data_o, 32'h8000_0100);

        // No forwarding on an unsupported address
        we_i = 1'b1; waddr_i = 32'h7C0; data_i = 32'h55; raddr_i = 32'h7C0;
        #1;
        check("no_fwd_unsup", data_o, 32'h0);
        tick(); idle();

        // Simultaneous writes: ex wins, clint dropped
        we_i = 1'b1; waddr_i = 32'h340; data_i = 32'h1111_1111;
        clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_data_i = 32'h2222_2222;
        tick(); idle();
        raddr_i = 32'h340; clint_raddr_i = 32'h341;
        #1;
        check("sim_mscratch", data_o, 32'h1111_1111);
        check("sim_mepc", clint_data_o, 32'h0);
        check("sim_mepc_out", clint_csr_mepc, 32'h0);

        // Clint exception sequence
        clint_we_i = 1'b1; clint_waddr_i = 32'h300; clint_data_i = 32'h08;
        tick(); idle();
        check("gie_on", {31'h0, global_int_en_o}, 32'h1);
        clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_data_i = 32'h40;
        tick(); idle();
        check("mepc_out", clint_csr_mepc, 32'h40);
        clint_we_i = 1'b1; clint_waddr_i = 32'h300; clint_data_i = 32'h80;
        clint_raddr_i = 32'h300;
        #1;
        check("clint_fwd_mstatus", clint_data_o, 32'h80);
        check("gie_still_on", {31'h0, global_int_en_o}, 32'h1);
        tick(); idle();
        check("gie_off", {31'h0, global_int_en_o}, 32'h0);
        check("mstatus_out", clint_csr_mstatus, 32'h80);
        clint_we_i = 1'b1; clint_waddr_i = 32'h342; clint_data_i = 32'h0B;
        tick(); idle();
        clint_raddr_i = 32'h342; raddr_i = 32'h341;
        #1;
        check("mcause_read", clint_data_o, 32'h0B);
        check("mepc_read_ex", data_o, 32'h40);

        // No cross-port forwarding (clint writes mscratch, ex reads it)
        clint_we_i = 1'b1; clint_waddr_i = 32'h340; clint_data_i = 32'h77;
        raddr_i = 32'h340;
        #1;
        check("no_cross_fwd", data_o, 32'h1111_1111);
        tick(); idle();
        check("clint_mscratch", data_o, 32'h77);

        // Full 32-bit storage in mie
        we_i = 1'b1; waddr_i = 32'h304; data_i = 32'hA5A5_5A5A;
        tick(); idle();
        raddr_i = 32'h304;
        #1;
        check("mie_read", data_o, 32'hA5A5_5A5A);

        // Counter wrap
        we_i = 1'b1; waddr_i = 32'hB00; data_i = 32'hFFFF_FFFE;
        tick();
        waddr_i = 32'hB80; data_i = 32'hFFFF_FFFF;
        raddr_i = 32'hB80;
        #1;
        check("mcycleh_fwd", data_o, 32'hFFFF_FFFF);
        tick(); idle();
        raddr_i = 32'hB00; clint_raddr_i = 32'hB80;
        #1;
        check("cnt_lo_held", data_o, 32'hFFFF_FFFE);
        check("cnt_hi_loaded", clint_data_o, 32'hFFFF_FFFF);
        tick();
        check("cnt_lo_max", data_o, 32'hFFFF_FFFF);
        tick();
        check("cnt_wrap_lo", data_o, 32'h0);
        check("cnt_wrap_hi", clint_data_o, 32'h0);

        // cycleh is read-only
        we_i = 1'b1; waddr_i = 32'hC80; data_i = 32'h1234;
        raddr_i = 32'hC00; clint_raddr_i = 32'hC80;
        tick(); idle();
        check("cycle_after_ro", data_o, 32'h1);
        check("cycleh_ro", clint_data_o, 32'h0);

        // Carry from low to high half
        we_i = 1'b1; waddr_i = 32'hB00; data_i = 32'hFFFF_FFFF;
        tick(); idle();
        tick();
        check("carry_lo", data_o, 32'h0);
        check("carry_hi", clint_data_o, 32'h1);

        // Zero address write from clint idle pattern is ignored
        clint_we_i = 1'b1; clint_waddr_i = 32'h0; clint_data_i = 32'hDEAD_BEEF;
        tick(); idle();
        raddr_i = 32'h7C0; clint_raddr_i = 32'h0;
        #1;
        check("zero_mtvec", clint_csr_mtvec, 32'h8000_0100);
        check("zero_mepc", clint_csr_mepc, 32'h40);
        check("zero_mstatus", clint_csr_mstatus, 32'h80);
        check("read_7c0", data_o, 32'h0);
        check("read_000", clint_data_o, 32'h0);

        // Reset mid-operation
        we_i = 1'b1; waddr_i = 32'h300; data_i = 32'h08;
        tick(); idle();
        check("pre_rst_gie", {31'h0, global_int_en_o}, 32'h1);
        rst = 1'b1; we_i = 1'b1; waddr_i = 32'h305; data_i = 32'h0000_FFFF;
        raddr_i = 32'h305; clint_raddr_i = 32'h300;
        #1;
        check("rst_comb_data_o", data_o, 32'h0);
        check("rst_comb_clint", clint_data_o, 32'h0);
        check("rst_comb_gie", {31'h0, global_int_en_o}, 32'h0);
        tick(); idle();
        rst = 1'b0; raddr_i = 32'hB00;
        #1;
        check("rst_wr_ignored", clint_csr_mtvec, 32'h0);
        check("rst_mstatus_clr", clint_data_o, 32'h0);
        check("rst_cnt_zero", data_o, 32'h0);
        tick();
        check("rst_cnt_restart", data_o, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
